// File: rtl/fp32_mul_core.sv
// IEEE-754 single-precision multiplier, RNE rounding, subnormals flushed to zero.
// Latency: start accepted at edge N, o_Done pulses in cycle N+5; fixed for all operand classes.
// Backpressure: none; i_Start is only sampled in IDLE, so requests while busy are dropped.
module fp32_mul_core #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [31:0] o_Result,
  output logic        o_Invalid,
  output logic        o_Overflow,
  output logic        o_Underflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched operands
  logic [31:0] a_q, b_q;

  // UNPACK stage results
  logic               sign_q;
  logic [23:0]        ma_q, mb_q;
  logic signed [9:0]  exp_u_q;
  logic               spec_q;
  logic [31:0]        spec_res_q;
  logic               spec_inv_q;

  // MUL stage result
  logic [47:0]        prod_q;

  // NORM stage results
  logic [23:0]        kept_q;
  logic               guard_q, sticky_q;
  logic signed [9:0]  exp_n_q;

  // State register; reset always wins over a concurrent start
  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state sequencing: one cycle per stage after acceptance
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_Start) state_d = S_UNPACK;
      S_UNPACK: state_d = S_MUL;
      S_MUL:    state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign o_Busy = (state_q != S_IDLE);
  assign o_Done = (state_q == S_DONE);

  // Capture operands at acceptance so later input changes cannot disturb the operation
  always_ff @(posedge i_Clock) begin
    if (state_q == S_IDLE && i_Start) begin
      a_q <= i_A;
      b_q <= i_B;
    end
  end

  // Operand classification and special-case resolution
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              sign_u;
  logic              spec_u, spec_inv_u;
  logic [31:0]       spec_res_u;
  logic signed [9:0] exp_sum_u;

  // Exponent-zero operands count as zero whatever their fraction (flush-to-zero)
  always_comb begin
    ea         = a_q[30:23];
    eb         = b_q[30:23];
    fa         = a_q[22:0];
    fb         = b_q[22:0];
    a_zero     = (ea == 8'h00);
    b_zero     = (eb == 8'h00);
    a_inf      = (ea == 8'hFF) && (fa == 23'h0);
    b_inf      = (eb == 8'hFF) && (fb == 23'h0);
    a_nan      = (ea == 8'hFF) && (fa != 23'h0);
    b_nan      = (eb == 8'hFF) && (fb != 23'h0);
    sign_u     = a_q[31] ^ b_q[31];
    exp_sum_u  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    spec_u     = 1'b0;
    spec_inv_u = 1'b0;
    spec_res_u = 32'h0;
    if (a_nan || b_nan) begin
      spec_u     = 1'b1;
      spec_inv_u = 1'b1;
      spec_res_u = QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_u     = 1'b1;
      spec_inv_u = 1'b1;
      spec_res_u = QNAN;
    end else if (a_inf || b_inf) begin
      spec_u     = 1'b1;
      spec_res_u = {sign_u, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      spec_u     = 1'b1;
      spec_res_u = {sign_u, 31'h0};
    end
  end

  // UNPACK stage register
  always_ff @(posedge i_Clock) begin
    if (state_q == S_UNPACK) begin
      sign_q     <= sign_u;
      ma_q       <= {1'b1, fa};
      mb_q       <= {1'b1, fb};
      exp_u_q    <= exp_sum_u;
      spec_q     <= spec_u;
      spec_res_q <= spec_res_u;
      spec_inv_q <= spec_inv_u;
    end
  end

  // MUL stage: full 24x24 mantissa product
  always_ff @(posedge i_Clock) begin
    if (state_q == S_MUL) prod_q <= {24'h0, ma_q} * {24'h0, mb_q};
  end

  // NORM stage: product of two [1,2) mantissas lies in [1,4), so at most one shift
  always_ff @(posedge i_Clock) begin
    if (state_q == S_NORM) begin
      if (prod_q[47]) begin
        kept_q   <= prod_q[47:24];
        guard_q  <= prod_q[23];
        sticky_q <= |prod_q[22:0];
        exp_n_q  <= exp_u_q + 10'sd1;
      end else begin
        kept_q   <= prod_q[46:23];
        guard_q  <= prod_q[22];
        sticky_q <= |prod_q[21:0];
        exp_n_q  <= exp_u_q;
      end
    end
  end

  // ROUND: round-to-nearest-even, then range check against the biased exponent
  logic              inc_r;
  logic [24:0]       sum_r;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_r;
  logic [31:0]       res_d;
  logic              inv_d, ovf_d, unf_d;

  always_comb begin
    inc_r  = guard_q & (sticky_q | kept_q[0]);
    sum_r  = {1'b0, kept_q} + {24'h0, inc_r};
    mant_r = sum_r[23:0];
    exp_r  = exp_n_q;
    if (sum_r[24]) begin
      mant_r = 24'h80_0000;
      exp_r  = exp_n_q + 10'sd1;
    end
    inv_d = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    res_d = {sign_q, exp_r[7:0], mant_r[22:0]};
    if (spec_q) begin
      res_d = spec_res_q;
      inv_d = spec_inv_q;
    end else if (exp_r > 10'sd254) begin
      res_d = {sign_q, 8'hFF, 23'h0};
      ovf_d = 1'b1;
    end else if (exp_r < 10'sd1) begin
      res_d = {sign_q, 31'h0};
      unf_d = 1'b1;
    end
  end

  // Result and flags load on entry to DONE and hold until the next completion or reset
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Result    <= 32'h0;
      o_Invalid   <= 1'b0;
      o_Overflow  <= 1'b0;
      o_Underflow <= 1'b0;
    end else if (state_q == S_ROUND) begin
      o_Result    <= res_d;
      o_Invalid   <= inv_d;
      o_Overflow  <= ovf_d;
      o_Underflow <= unf_d;
    end
  end

endmodule
